// File: rtl/sdp_ram_pkg.sv
// sdp_ram_pkg: state encoding and per-column merge helper shared by the SDP BRAM files
//   ST_IDLE / ST_SWEEP : sweep FSM state encoding
//   col_merge          : per-column select of nw (mask bit set) or od (mask bit clear)
package sdp_ram_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SWEEP = 1'b1;

    // Widest word the merge helper handles; callers zero-extend into these widths.
    localparam int MAX_COL = 64;
    localparam int MAX_W   = 1024;

    function automatic logic [MAX_W-1:0] col_merge(
        input logic [MAX_COL-1:0] mask,
        input logic [MAX_W-1:0]   nw,
        input logic [MAX_W-1:0]   od,
        input int                 cw
    );
        logic [MAX_W-1:0] r;
        logic [9:0]       k;
        r = od;
        for (int i = 0; i < MAX_COL; i++)
            if (mask[i])
                for (int b = 0; b < cw; b++) begin
                    k    = 10'(i * cw + b);
                    r[k] = nw[k];
                end
        return r;
    endfunction

endpackage

// File: rtl/sdp_ram_core.sv
// sdp_ram_core: bare inferred simple dual-port block RAM, read-first, byte-column writes, no reset
//   clk   : clock
//   we    : per-column write enable
//   waddr : write address
//   wdata : write data
//   re    : read enable; rdata holds when low
//   raddr : read address
//   rdata : registered read data (old contents on a same-address write)
module sdp_ram_core #(
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                           clk,
    input  logic [NUM_COL-1:0]             we,
    input  logic [ADDR_WIDTH-1:0]          waddr,
    input  logic [NUM_COL*COL_WIDTH-1:0]   wdata,
    input  logic                           re,
    input  logic [ADDR_WIDTH-1:0]          raddr,
    output logic [NUM_COL*COL_WIDTH-1:0]   rdata
);

    logic [NUM_COL*COL_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (re)
            rdata <= mem[raddr];
        for (int i = 0; i < NUM_COL; i++)
            if (we[i])
                mem[waddr][i*COL_WIDTH +: COL_WIDTH] <= wdata[i*COL_WIDTH +: COL_WIDTH];
    end

endmodule

// File: rtl/sdp_bram_fwd_clr.sv
// sdp_bram_fwd_clr: SDP byte-write BRAM with write-first collision forwarding, zero-fill sweep and read-valid pipeline
//   clk     : clock
//   resetn  : asynchronous active-low reset; starts a full sweep
//   clr_req : pulse in idle to zero-fill the array
//   busy    : sweep in progress; user reads and writes are ignored
//   ren/raddr/rdata/rvalid : read port, latency 1 (2 with SDP_OUT_REG_EN)
//   wen/waddr/wdata        : write port, per-column enables
// Build option: SDP_OUT_REG_EN adds an output register stage.
module sdp_bram_fwd_clr
    import sdp_ram_pkg::*;
#(
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           clr_req,
    output logic                           busy,
    input  logic                           ren,
    input  logic [ADDR_WIDTH-1:0]          raddr,
    output logic [NUM_COL*COL_WIDTH-1:0]   rdata,
    output logic                           rvalid,
    input  logic [NUM_COL-1:0]             wen,
    input  logic [ADDR_WIDTH-1:0]          waddr,
    input  logic [NUM_COL*COL_WIDTH-1:0]   wdata
);

    localparam int W = NUM_COL * COL_WIDTH;

    logic                  state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [NUM_COL-1:0]    we, fmask;
    logic [ADDR_WIDTH-1:0] wa;
    logic [W-1:0]          wd, q, fdata, merged;
    logic [MAX_W-1:0]      mx;
    logic                  rd, v1;

    assign busy = (state == ST_SWEEP);
    assign rd   = ren && !busy;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_SWEEP;
            cnt   <= '0;
        end else if (state == ST_SWEEP) begin
            cnt <= cnt + 1'b1;
            if (&cnt)
                state <= ST_IDLE;
        end else if (clr_req) begin
            state <= ST_SWEEP;
            cnt   <= '0;
        end
    end

    // The sweep owns the write port; user writes are dropped while busy.
    assign we = busy ? '1  : wen;
    assign wa = busy ? cnt : waddr;
    assign wd = busy ? '0  : wdata;

    sdp_ram_core #(
        .NUM_COL    (NUM_COL),
        .COL_WIDTH  (COL_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clk   (clk),
        .we    (we),
        .waddr (wa),
        .wdata (wd),
        .re    (rd),
        .raddr (raddr),
        .rdata (q)
    );

    // The core is read-first; remember which columns were written at the read address
    // so the merge below turns the old data into write-first data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fmask <= '0;
            fdata <= '0;
            v1    <= 1'b0;
        end else begin
            v1 <= rd;
            if (rd) begin
                fmask <= (raddr == waddr) ? wen : '0;
                fdata <= wdata;
            end
        end
    end

    always_comb mx = col_merge(MAX_COL'(fmask), MAX_W'(fdata), MAX_W'(q), COL_WIDTH);
    assign merged = mx[W-1:0];

`ifdef SDP_OUT_REG_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= v1;
            if (v1)
                rdata <= merged;
        end
    end
`else
    logic have;

    // The core output is not reset, so mask it until the first read completes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            have <= 1'b0;
        else if (rd)
            have <= 1'b1;
    end

    assign rdata  = have ? merged : '0;
    assign rvalid = v1;
`endif

endmodule
